// File: rtl/alu_pkg.sv
// Operation codes and class constants shared by the ALU and its users.
// ALU_Control layout: [5:3] operation class, [2:0] funct3.
`timescale 1ns/1ps
package alu_pkg;

    // Operation classes (ALU_Control[5:3])
    localparam logic [2:0] ARITH     = 3'b000;
    localparam logic [2:0] ARITH_ALT = 3'b001;
    localparam logic [2:0] BRANCH    = 3'b010;
    localparam logic [2:0] JUMP      = 3'b011;

    // Full operation codes
    localparam logic [5:0] ALU_ADD  = 6'b000_000;
    localparam logic [5:0] ALU_SLL  = 6'b000_001;
    localparam logic [5:0] ALU_SLT  = 6'b000_010;
    localparam logic [5:0] ALU_SLTU = 6'b000_011;
    localparam logic [5:0] ALU_XOR  = 6'b000_100;
    localparam logic [5:0] ALU_SRL  = 6'b000_101;
    localparam logic [5:0] ALU_OR   = 6'b000_110;
    localparam logic [5:0] ALU_AND  = 6'b000_111;
    localparam logic [5:0] ALU_SUB  = 6'b001_000;
    localparam logic [5:0] ALU_SRA  = 6'b001_101;
    localparam logic [5:0] ALU_BEQ  = 6'b010_000;
    localparam logic [5:0] ALU_BNE  = 6'b010_001;
    localparam logic [5:0] ALU_BLT  = 6'b010_100;
    localparam logic [5:0] ALU_BGE  = 6'b010_101;
    localparam logic [5:0] ALU_BLTU = 6'b010_110;
    localparam logic [5:0] ALU_BGEU = 6'b010_111;
    localparam logic [5:0] ALU_PASS = 6'b011_111;

endpackage

// File: rtl/alu_compare.sv
// Shared comparator: equality plus signed and unsigned less-than.
// Feeds SLT/SLTU and all six branch conditions from one set of comparators.
`timescale 1ns/1ps
module alu_compare #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  eq,
    output logic                  lt_signed,
    output logic                  lt_unsigned
);

    assign eq          = (a == b);
    assign lt_unsigned = (a < b);
    assign lt_signed   = ($signed(a) < $signed(b));

endmodule

// File: rtl/alu.sv
// RV32I arithmetic/logic/compare unit for the execute stage.
// Compile-time option: define ALU_OUT_REG_EN to register ALU_result, zero and
// branch (1-cycle latency, async active-low reset clears them). Without it the
// unit is purely combinational and clock/reset are unused.
`timescale 1ns/1ps
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            ALU_Control,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    output logic [DATA_WIDTH-1:0] ALU_result,
    output logic                  zero,
    output logic                  branch
);

    localparam int SH_W = $clog2(DATA_WIDTH);

    logic [SH_W-1:0]       sh;
    logic                  cmp_eq;
    logic                  cmp_lt_signed;
    logic                  cmp_lt_unsigned;
    logic [DATA_WIDTH-1:0] result_next;
    logic                  branch_next;
    logic                  zero_next;
    logic                  branch_bit;

    // Only the low log2(DATA_WIDTH) bits of B form the shift amount
    assign sh = operand_B[SH_W-1:0];

    alu_compare #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_compare (
        .a           (operand_A),
        .b           (operand_B),
        .eq          (cmp_eq),
        .lt_signed   (cmp_lt_signed),
        .lt_unsigned (cmp_lt_unsigned)
    );

    // Branch condition selected by funct3; 010/011 are not branch codes
    always_comb begin
        branch_bit = 1'b0;
        case (ALU_Control[2:0])
            3'b000:  branch_bit = cmp_eq;
            3'b001:  branch_bit = !cmp_eq;
            3'b100:  branch_bit = cmp_lt_signed;
            3'b101:  branch_bit = !cmp_lt_signed;
            3'b110:  branch_bit = cmp_lt_unsigned;
            3'b111:  branch_bit = !cmp_lt_unsigned;
            default: branch_bit = 1'b0;
        endcase
    end

    // Operation select; unlisted codes yield 0 so nothing undefined leaks out
    always_comb begin
        result_next = '0;
        branch_next = 1'b0;
        case (ALU_Control)
            ALU_ADD:  result_next = operand_A + operand_B;
            ALU_SUB:  result_next = operand_A - operand_B;
            ALU_SLL:  result_next = operand_A << sh;
            ALU_SRL:  result_next = operand_A >> sh;
            ALU_SRA:  result_next = $signed(operand_A) >>> sh;
            ALU_SLT:  result_next = {{(DATA_WIDTH-1){1'b0}}, cmp_lt_signed};
            ALU_SLTU: result_next = {{(DATA_WIDTH-1){1'b0}}, cmp_lt_unsigned};
            ALU_XOR:  result_next = operand_A ^ operand_B;
            ALU_OR:   result_next = operand_A | operand_B;
            ALU_AND:  result_next = operand_A & operand_B;
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: begin
                result_next = {{(DATA_WIDTH-1){1'b0}}, branch_bit};
                branch_next = branch_bit;
            end
            ALU_PASS: result_next = operand_A;
            default: begin
                result_next = '0;
                branch_next = 1'b0;
            end
        endcase
    end

    // Zero flag always reflects the final result, branch codes included
    assign zero_next = (result_next == '0);

`ifdef ALU_OUT_REG_EN
    logic [DATA_WIDTH-1:0] result_reg;
    logic                  zero_reg;
    logic                  branch_reg;

    // Output register; reset discards any in-flight result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
            branch_reg <= 1'b0;
        end else begin
            result_reg <= result_next;
            zero_reg   <= zero_next;
            branch_reg <= branch_next;
        end
    end

    assign ALU_result = result_reg;
    assign zero       = zero_reg;
    assign branch     = branch_reg;
`else
    // Clock and reset are intentionally unused in the combinational build
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clock, reset};

    assign ALU_result = result_next;
    assign zero       = zero_next;
    assign branch     = branch_next;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized operations
// checked against an arithmetic reference model. Handles both the
// combinational build and the ALU_OUT_REG_EN registered build.
`timescale 1ns/1ps
module tb_alu;

    logic        clock;
    logic        reset;
    logic [5:0]  ALU_Control;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [31:0] ALU_result;
    logic        zero;
    logic        branch;

    int n_checks = 0;
    int n_fail   = 0;

    alu #(.DATA_WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .ALU_Control (ALU_Control),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .ALU_result  (ALU_result),
        .zero        (zero),
        .branch      (branch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: values computed as plain integers
    function automatic void ref_model(input logic [5:0] c, input logic [31:0] a,
                                      input logic [31:0] b,
                                      output logic [31:0] r, output logic br);
        longint ua, ub, sa, sb, p2;
        int     sh;
        logic   cond;
        logic   is_br;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
        sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
        sh = int'(b % 32);
        p2 = longint'(1) << sh;
        r = 32'h0;
        br = 1'b0;
        cond = 1'b0;
        is_br = 1'b0;
        case (c)
            6'b000_000: r = 32'((ua + ub) % 64'sh1_0000_0000);
            6'b001_000: r = 32'((ua - ub + 64'sh1_0000_0000) % 64'sh1_0000_0000);
            6'b000_001: r = 32'((ua * p2) % 64'sh1_0000_0000);
            6'b000_101: r = 32'(ua / p2);
            6'b000_101 + 6'b001_000: begin
                // floor division of the signed value by 2^sh
                if (sa >= 0) r = 32'(sa / p2);
                else         r = 32'(-((-sa + p2 - 1) / p2));
            end
            6'b000_010: r = (sa < sb) ? 32'd1 : 32'd0;
            6'b000_011: r = (ua < ub) ? 32'd1 : 32'd0;
            6'b000_100: r = a ^ b;
            6'b000_110: r = a | b;
            6'b000_111: r = a & b;
            6'b010_000: begin is_br = 1'b1; cond = (ua == ub); end
            6'b010_001: begin is_br = 1'b1; cond = (ua != ub); end
            6'b010_100: begin is_br = 1'b1; cond = (sa <  sb); end
            6'b010_101: begin is_br = 1'b1; cond = (sa >= sb); end
            6'b010_110: begin is_br = 1'b1; cond = (ua <  ub); end
            6'b010_111: begin is_br = 1'b1; cond = (ua >= ub); end
            6'b011_111: r = a;
            default:    r = 32'h0;
        endcase
        if (is_br) begin
            r  = cond ? 32'd1 : 32'd0;
            br = cond;
        end
    endfunction

    // Drive one operation and wait until its outputs are observable
    task automatic apply(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        ALU_Control = c;
        operand_A   = a;
        operand_B   = b;
`ifdef ALU_OUT_REG_EN
        @(posedge clock);
        #1;
`else
        #1;
`endif
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction: apply, compare result/zero/branch against the model
    task automatic check_op(input string tag, input logic [5:0] c,
                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        eb;
        ref_model(c, a, b, er, eb);
        apply(c, a, b);
        $display("%s code=%b A=%h B=%h -> result=%h zero=%b branch=%b",
                 tag, c, a, b, ALU_result, zero, branch);
        cmp({tag, ".result"}, ALU_result, er);
        cmp({tag, ".zero"},   {31'h0, zero},   {31'h0, (er == 32'h0)});
        cmp({tag, ".branch"}, {31'h0, branch}, {31'h0, eb});
    endtask

    logic [5:0] legal_codes [17] = '{6'o00, 6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06,
                                      6'o07, 6'o10, 6'o15, 6'o20, 6'o21, 6'o24, 6'o25,
                                      6'o26, 6'o27, 6'o37};

    initial begin
        logic [5:0]  rc;
        logic [31:0] ra, rb;

        ALU_Control = 6'b0;
        operand_A   = 32'h0;
        operand_B   = 32'h0;
        reset       = 1'b0;
        #12;

`ifdef ALU_OUT_REG_EN
        // Reset state: all outputs held at 0 while reset is low
        operand_A = 32'h5; operand_B = 32'h6; ALU_Control = 6'b000_000;
        @(posedge clock); #1;
        cmp("reset.result", ALU_result, 32'h0);
        cmp("reset.zero",   {31'h0, zero},   32'h0);
        cmp("reset.branch", {31'h0, branch}, 32'h0);
        reset = 1'b1;
`else
        // Reset is ignored in the combinational build
        check_op("reset_ignored", 6'b000_000, 32'h5, 32'h6);
        reset = 1'b1;
`endif

        // Directed cases
        check_op("add_wrap",  6'b000_000, 32'hFFFF_FFFF, 32'h1);
        check_op("sub",       6'b001_000, 32'hFFFF_FFFF, 32'h1);
        cmp("sub_value", ALU_result, 32'hFFFF_FFFE);
        check_op("srl",       6'b000_101, 32'h8000_0000, 32'h21);
        cmp("srl_value", ALU_result, 32'h4000_0000);
        check_op("sra",       6'b001_101, 32'h8000_0000, 32'h21);
        cmp("sra_value", ALU_result, 32'hC000_0000);
        check_op("sll",       6'b000_001, 32'h8000_0000, 32'h21);
        check_op("slt",       6'b000_010, 32'hFFFF_FFFF, 32'h1);
        cmp("slt_value", ALU_result, 32'h1);
        check_op("sltu",      6'b000_011, 32'hFFFF_FFFF, 32'h1);
        check_op("blt",       6'b010_100, 32'hFFFF_FFFF, 32'h1);
        cmp("blt_taken", {31'h0, branch}, 32'h1);
        check_op("bgeu",      6'b010_111, 32'hFFFF_FFFF, 32'h1);
        check_op("bltu",      6'b010_110, 32'hFFFF_FFFF, 32'h1);
        check_op("beq",       6'b010_000, 32'h1234_5678, 32'h1234_5678);
        cmp("beq_taken", {31'h0, branch}, 32'h1);
        check_op("bne",       6'b010_001, 32'h1234_5678, 32'h1234_5678);
        check_op("bge_eq",    6'b010_101, 32'h8000_0000, 32'h8000_0000);
        check_op("pass",      6'b011_111, 32'h0000_1004, 32'hDEAD_BEEF);
        cmp("pass_value", ALU_result, 32'h0000_1004);
        check_op("illegal_br", 6'b010_010, 32'h0000_1004, 32'h0000_0003);
        check_op("illegal_alt", 6'b001_001, 32'hFFFF_0000, 32'h0000_0004);
        check_op("illegal_jmp", 6'b011_000, 32'h0000_1004, 32'h0000_0004);

`ifdef ALU_OUT_REG_EN
        // Latency: new result appears only at the next posedge
        ALU_Control = 6'b000_000; operand_A = 32'd3; operand_B = 32'd4;
        #1;
        cmp("latency_hold", ALU_result, 32'h0);
        @(posedge clock); #1;
        cmp("latency_add", ALU_result, 32'd7);
        // Reset between edges clears outputs at once
        ALU_Control = 6'b010_000; operand_A = 32'd9; operand_B = 32'd9;
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        cmp("midreset.result", ALU_result, 32'h0);
        cmp("midreset.zero",   {31'h0, zero},   32'h0);
        cmp("midreset.branch", {31'h0, branch}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
`endif

        // Randomized operations
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) rc = 6'($urandom_range(0, 63));
            else rc = legal_codes[$urandom_range(0, 16)];
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = 32'($urandom_range(0, 40));
                2:       rb = ra ^ 32'h8000_0000;
                default: rb = $urandom;
            endcase
            check_op("rand", rc, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Combinational RV32I arithmetic/logic/compare unit inside `execution_unit` of the 5-stage BRISC-V pipeline. It takes a 6-bit control code built by the execute stage from ALU_Operation/funct3/funct7, plus two operands. It produces the result, a zero flag and a branch-taken flag, so JAL/JALR link values, R/I-type arithmetic and conditional branches all resolve in EX. An optional output register stage is selectable at compile time.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, ≥ 8.
- clock  input  1  sole clock; used only by the optional output register.
- reset  input  1  asynchronous, active-low; clears the optional output register.
- ALU_Control  input  6  operation code; `[5:3]` class, `[2:0]` funct3.
- operand_A  input  DATA_WIDTH  first operand (rs1, PC or PC+4, chosen upstream).
- operand_B  input  DATA_WIDTH  second operand (rs2 or sign-extended immediate).
- ALU_result  output  DATA_WIDTH  operation result.
- zero  output  1  high when ALU_result == 0.
- branch  output  1  branch condition true; branch-class codes only.

## Operation
- Shift amount `sh` = operand_B[log2(DATA_WIDTH)-1:0]; upper bits of B are ignored.
- 000_000 ADD: A+B, modulo 2^DATA_WIDTH.
- 000_001 SLL: A<<sh.
- 000_010 SLT: signed A<B gives 1, else 0.
- 000_011 SLTU: unsigned A<B gives 1, else 0.
- 000_100 XOR. 000_110 OR. 000_111 AND.
- 000_101 SRL: logical A>>sh.
- 001_000 SUB: A−B, modulo 2^DATA_WIDTH.
- 001_101 SRA: arithmetic A>>>sh (sign-filled).
- Branch class 010_fff: ALU_result = zero-extended 1-bit comparison; branch = that bit.
  - 000 BEQ: A==B.
  - 001 BNE: A!=B.
  - 100 BLT: signed A<B.
  - 101 BGE: signed A≥B.
  - 110 BLTU: unsigned A<B.
  - 111 BGEU: unsigned A≥B.
- 011_111 PASS: ALU_result = operand_A (JAL/JALR link value); branch = 0.
- Every other code, including 010_010/010_011 and the remaining 001_xxx and 011_xxx codes: ALU_result = 0, branch = 0, zero = 1.
- branch is 0 for every non-branch-class code.
- zero is always derived from the final ALU_result, including for branch codes.
- Signed comparisons use two's complement at DATA_WIDTH; unsigned comparisons use raw bits.
- No X propagation from the unselected operation paths.

## Timing
- Default build: purely combinational, zero latency; clock and reset are ignored. All outputs follow inputs within the same cycle.
- Registered build (see Configuration): ALU_result, zero and branch update on posedge clock with 1-cycle latency.
  - While reset is low, all three outputs are 0 immediately, independent of clock.
  - Reset asserted mid-operation discards the in-flight result.
  - Outputs are valid again from the first posedge after reset deasserts.

## Configuration
- `ALU_OUT_REG_EN` defined: the three outputs are registered as described in Timing; reset value is 0 for every output.
- `ALU_OUT_REG_EN` undefined: outputs are combinational; clock and reset ports exist but are unconnected internally.

## Structure
- Package `alu_pkg` holds:
  - class constants: ARITH=3'b000, ARITH_ALT=3'b001, BRANCH=3'b010, JUMP=3'b011;
  - full 6-bit localparams for each operation listed above, including ALU_PASS=6'b011_111.
- One natural sub-module, `alu_compare`. It takes A and B and returns eq, lt_signed and lt_unsigned, shared by SLT/SLTU and all six branch conditions.

## Test plan
- ADD/SUB wrap: A=32'hFFFF_FFFF, B=1, code 000_000 → result 0, zero=1. Same operands, code 001_000 → result 32'hFFFF_FFFE, zero=0.
- Shifts: A=32'h8000_0000, B=32'h0000_0021 (sh=1):
  - SRL → 32'h4000_0000;
  - SRA → 32'hC000_0000;
  - SLL → 0, zero=1.
- Signed vs unsigned compare: A=32'hFFFF_FFFF, B=1:
  - SLT → 1;
  - SLTU → 0;
  - BLT → branch=1;
  - BGEU → branch=1;
  - BLTU → branch=0.
- Equality: A=B=32'h1234_5678:
  - BEQ → branch=1, result=1, zero=0;
  - BNE → branch=0, result=0, zero=1.
- PASS and illegal codes: A=32'h0000_1004, code 011_111 → result 32'h0000_1004, branch=0. Code 010_010 → result 0, branch=0, zero=1.
- With `ALU_OUT_REG_EN`:
  - ADD 3+4 → result 7 appears one posedge later.
  - Asserting reset low between edges → all outputs 0 immediately.
